// File: rtl/serial_word_tx.sv
// serial_word_tx
// Bit-serial transmitter feeding the serial two's-complement inverter stage.
// A parallel WIDTH-bit word is accepted on a valid/ready handshake and shifted
// out LSB first, one bit per clock. ser_frame marks bit 0 of every word (it
// restarts the inverter's "first one seen" state); ser_last marks bit WIDTH-1.
//
// Optional feature macro: SERIAL_TX_PREFETCH_EN
//   defined   -> one-word holding register, words go out back to back
//   undefined -> no holding register, one idle cycle between words
//
// Ports:
//   t_clock    in   clock, rising edge
//   r_n        in   asynchronous active-low reset
//   in_data    in   parallel word, sampled on in_valid && in_ready
//   in_valid   in   in_data is valid
//   in_ready   out  block can accept a word this cycle (low while r_n is low)
//   ser_bit    out  serial data bit, LSB first
//   ser_valid  out  ser_bit carries a word bit this cycle
//   ser_frame  out  high on bit 0 of each word
//   ser_last   out  high on bit WIDTH-1 of each word
module serial_word_tx #(
  parameter int WIDTH = 8
) (
  input  logic             t_clock,
  input  logic             r_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             ser_frame,
  output logic             ser_last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             xfer;
  logic             at_last;

`ifdef SERIAL_TX_PREFETCH_EN
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;

  assign in_ready = r_n & ~hold_full_q;
`else
  assign in_ready = r_n & (state_q == IDLE);
`endif

  assign xfer    = in_valid & in_ready;
  assign at_last = (state_q == SHIFT) && (cnt_q == LAST_CNT);

  // Outputs come straight from the registered state; the SHIFT gating keeps
  // ser_bit at 0 while idle.
  assign ser_valid = (state_q == SHIFT);
  assign ser_bit   = ser_valid & shift_q[0];
  assign ser_frame = ser_valid && (cnt_q == '0);
  assign ser_last  = at_last;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_TX_PREFETCH_EN
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
`endif
    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d = SHIFT;
          shift_d = in_data;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (at_last) begin
`ifdef SERIAL_TX_PREFETCH_EN
          // A held word has priority over a word arriving on this edge.
          if (hold_full_q) begin
            shift_d     = hold_q;
            cnt_d       = '0;
            hold_full_d = 1'b0;
          end else if (xfer) begin
            shift_d = in_data;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
            shift_d = '0;
            cnt_d   = '0;
          end
`else
          state_d = IDLE;
          shift_d = '0;
          cnt_d   = '0;
`endif
        end else begin
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        shift_d = '0;
        cnt_d   = '0;
      end
    endcase
`ifdef SERIAL_TX_PREFETCH_EN
    // A transfer during SHIFT fills the holding register, except on the
    // last-bit edge with the holder empty, where the word loads the shifter
    // directly. Placed last so a same-edge drain and fill leaves it full.
    if (xfer && (state_q == SHIFT) && !(at_last && !hold_full_q)) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge t_clock or negedge r_n) begin
    if (!r_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
`ifdef SERIAL_TX_PREFETCH_EN
      hold_q      <= '0;
      hold_full_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_TX_PREFETCH_EN
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// Self-checking bench for serial_word_tx (WIDTH=8 and WIDTH=4 instances).
module tb_serial_word_tx;

  logic       t_clock;
  logic       r_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       o_ready, o_bit, o_valid, o_frame, o_last;

  logic [3:0] d4_data;
  logic       d4_valid;
  logic       d4_ready, d4_bit, d4_sval, d4_frame, d4_last;

  int errors = 0;
  int checks = 0;

  // Per-cycle log of the WIDTH=8 outputs, sampled on the falling edge.
  logic lv[$];
  logic lb[$];
  logic lf[$];
  logic ll[$];
  logic lr[$];
  logic [7:0] rec[$];
  int xfers;
  int first_xfer_rec;
  int first_frame;
  int first_valid;
  int nvalid, nframe, nlast;

  serial_word_tx #(.WIDTH(8)) dut8 (
    .t_clock  (t_clock),
    .r_n      (r_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (o_ready),
    .ser_bit  (o_bit),
    .ser_valid(o_valid),
    .ser_frame(o_frame),
    .ser_last (o_last)
  );

  serial_word_tx #(.WIDTH(4)) dut4 (
    .t_clock  (t_clock),
    .r_n      (r_n),
    .in_data  (d4_data),
    .in_valid (d4_valid),
    .in_ready (d4_ready),
    .ser_bit  (d4_bit),
    .ser_valid(d4_sval),
    .ser_frame(d4_frame),
    .ser_last (d4_last)
  );

  initial t_clock = 1'b0;
  always #5 t_clock = ~t_clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Offers up to three words in order, each held on in_valid until it is
  // accepted, and logs the outputs for ncycles falling edges.
  task automatic applyStimulus(input logic [7:0] w0, input logic [7:0] w1,
                               input logic [7:0] w2, input int nwords,
                               input int ncycles);
    int  idx;
    logic pend;
    idx  = 0;
    pend = 1'b0;
    lv.delete(); lb.delete(); lf.delete(); ll.delete(); lr.delete();
    xfers = 0;
    first_xfer_rec = -1;
    for (int c = 0; c < ncycles; c++) begin
      @(negedge t_clock);
      lv.push_back(o_valid);
      lb.push_back(o_bit);
      lf.push_back(o_frame);
      ll.push_back(o_last);
      lr.push_back(o_ready);
      if (pend) begin
        idx++;
        xfers++;
      end
      if (idx < nwords) begin
        in_valid = 1'b1;
        in_data  = (idx == 0) ? w0 : ((idx == 1) ? w1 : w2);
      end else begin
        in_valid = 1'b0;
        in_data  = 8'h00;
      end
      pend = in_valid && o_ready;
      if (pend && first_xfer_rec < 0) first_xfer_rec = c;
    end
    in_valid = 1'b0;
  endtask

  // Rebuilds words from the log, framed by ser_frame and closed by ser_last.
  task automatic analyzeLog();
    int pos;
    logic [7:0] cur;
    pos = 0;
    cur = 8'h00;
    rec.delete();
    nvalid = 0; nframe = 0; nlast = 0;
    first_frame = -1;
    first_valid = -1;
    for (int i = 0; i < lv.size(); i++) begin
      if (lv[i]) begin
        nvalid++;
        if (first_valid < 0) first_valid = i;
        if (lf[i]) begin
          nframe++;
          if (first_frame < 0) first_frame = i;
          pos = 0;
          cur = 8'h00;
        end
        if (pos < 8) cur[pos] = lb[i];
        pos++;
        if (ll[i]) begin
          nlast++;
          rec.push_back(cur);
        end
      end
    end
  endtask

  initial begin
    int   f;
    int   ready_hi;
    int   nl;
    logic seen;
    logic [7:0] inv;
    logic [3:0] w4;
    int   fr4, la4;

    r_n      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    d4_valid = 1'b0;
    d4_data  = 4'h0;

    // Reset state
    repeat (3) @(negedge t_clock);
    checkOutput("rst_valid", 32'(o_valid), 32'd0);
    checkOutput("rst_bit",   32'(o_bit),   32'd0);
    checkOutput("rst_frame", 32'(o_frame), 32'd0);
    checkOutput("rst_last",  32'(o_last),  32'd0);
    checkOutput("rst_ready", 32'(o_ready), 32'd0);
    checkOutput("rst_ready4", 32'(d4_ready), 32'd0);
    r_n = 1'b1;
    #1;
    checkOutput("rel_ready", 32'(o_ready), 32'd1);

    // Single word 8'h2C
    applyStimulus(8'h2C, 8'h00, 8'h00, 1, 14);
    analyzeLog();
    checkOutput("single_xfers", 32'(xfers), 32'd1);
    checkOutput("single_latency", 32'(first_frame), 32'(first_xfer_rec + 1));
    checkOutput("single_nvalid", 32'(nvalid), 32'd8);
    checkOutput("single_nlast", 32'(nlast), 32'd1);
    if (rec.size() > 0) checkOutput("single_word", 32'(rec[0]), 32'h2C);
    else checkOutput("single_word_seen", 32'(rec.size()), 32'd1);
    f = first_frame;
    if (f >= 0 && f + 8 < lv.size()) begin
      checkOutput("single_last_pos", 32'(ll[f+7]), 32'd1);
      checkOutput("single_after_idle", 32'(lv[f+8]), 32'd0);
      seen = 1'b0;
      inv  = 8'h00;
      for (int i = 0; i < 8; i++) begin
        inv[i] = seen ? ~lb[f+i] : lb[f+i];
        if (lb[f+i]) seen = 1'b1;
      end
      checkOutput("single_inverted", 32'(inv), 32'hD4);
    end else begin
      checkOutput("single_frame_found", 32'(f), 32'd0);
    end

    // Back-to-back words 8'h01 then 8'h80
    applyStimulus(8'h01, 8'h80, 8'h00, 2, 28);
    analyzeLog();
    checkOutput("b2b_xfers", 32'(xfers), 32'd2);
    checkOutput("b2b_nvalid", 32'(nvalid), 32'd16);
    checkOutput("b2b_nwords", 32'(rec.size()), 32'd2);
    if (rec.size() == 2) begin
      checkOutput("b2b_word0", 32'(rec[0]), 32'h01);
      checkOutput("b2b_word1", 32'(rec[1]), 32'h80);
    end
    f = first_frame;
    if (f >= 0 && f + 9 < lv.size()) begin
      ready_hi = 0;
      for (int i = 1; i < 8; i++) if (lr[f+i]) ready_hi++;
      checkOutput("b2b_ready_low", 32'(ready_hi), 32'd0);
`ifdef SERIAL_TX_PREFETCH_EN
      checkOutput("b2b_contig_frame", 32'(lf[f+8]), 32'd1);
      checkOutput("b2b_contig_valid", 32'(lv[f+8]), 32'd1);
`else
      checkOutput("b2b_gap_valid", 32'(lv[f+8]), 32'd0);
      checkOutput("b2b_gap_next_frame", 32'(lf[f+9]), 32'd1);
`endif
    end else begin
      checkOutput("b2b_frame_found", 32'(f), 32'd0);
    end

    // Stall: three words offered continuously, each sent exactly once
    applyStimulus(8'hA5, 8'h5A, 8'hFF, 3, 40);
    analyzeLog();
    checkOutput("stall_xfers", 32'(xfers), 32'd3);
    checkOutput("stall_nvalid", 32'(nvalid), 32'd24);
    checkOutput("stall_nframe", 32'(nframe), 32'd3);
    if (rec.size() == 3) begin
      checkOutput("stall_word0", 32'(rec[0]), 32'hA5);
      checkOutput("stall_word1", 32'(rec[1]), 32'h5A);
      checkOutput("stall_word2", 32'(rec[2]), 32'hFF);
    end else begin
      checkOutput("stall_nwords", 32'(rec.size()), 32'd3);
    end

    // Reset in the middle of 8'hFF
    @(negedge t_clock);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(negedge t_clock);
    in_valid = 1'b0;
    nl = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge t_clock);
      checkOutput("mid_bit_on", 32'({o_valid, o_bit}), 32'h3);
      if (o_last) nl++;
    end
    #2;
    r_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(o_valid), 32'd0);
    checkOutput("mid_rst_bit",   32'(o_bit),   32'd0);
    checkOutput("mid_rst_frame", 32'(o_frame), 32'd0);
    checkOutput("mid_rst_last",  32'(o_last),  32'd0);
    checkOutput("mid_rst_ready", 32'(o_ready), 32'd0);
    checkOutput("mid_no_last", 32'(nl), 32'd0);
    @(negedge t_clock);
    @(negedge t_clock);
    r_n = 1'b1;
    #1;
    checkOutput("mid_rel_ready", 32'(o_ready), 32'd1);
    applyStimulus(8'h96, 8'h00, 8'h00, 1, 14);
    analyzeLog();
    if (first_valid >= 0) checkOutput("post_rst_frame", 32'(lf[first_valid]), 32'd1);
    else checkOutput("post_rst_valid_seen", 32'(first_valid), 32'd0);
    checkOutput("post_rst_nlast", 32'(nlast), 32'd1);
    if (rec.size() > 0) checkOutput("post_rst_word", 32'(rec[0]), 32'h96);

    // WIDTH=4 instance: 4'hF
    @(negedge t_clock);
    checkOutput("w4_ready", 32'(d4_ready), 32'd1);
    d4_valid = 1'b1;
    d4_data  = 4'hF;
    @(negedge t_clock);
    d4_valid = 1'b0;
    d4_data  = 4'h0;
    w4  = 4'h0;
    fr4 = -1;
    la4 = -1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge t_clock);
      if (d4_sval) w4[i] = d4_bit;
      if (d4_frame) fr4 = i;
      if (d4_last) la4 = i;
    end
    checkOutput("w4_word", 32'(w4), 32'hF);
    checkOutput("w4_frame_pos", 32'(fr4), 32'd0);
    checkOutput("w4_frame_last_gap", 32'(la4 - fr4), 32'd3);
    @(negedge t_clock);
    checkOutput("w4_idle_after", 32'(d4_sval), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
